reg_dump_reader: RTL and testbench
==================================

// Module: reg_dump_reader
// PURPOSE
//  Debug reader for the CPU register file: on a start pulse, walks register indices FIRST_REG..LAST_REG.
//  Drives the register file's second (combinational) read port, captures each word, and presents it downstream.
//  Downstream is the board display / UART shim, using a valid/ready handshake.
//  Sits beside the datapath; the port mux onto the register file read port is outside this block.
// PARAMETERS
//  FIRST_REG   0   first register index dumped
//  LAST_REG    31  last register index dumped (FIRST_REG <= LAST_REG <= 31)
//  DATA_WIDTH  32  register word width
// PORTS
//  clock        in   1           single clock; all state updates on posedge
//  reset        in   1           synchronous, active-high
//  start        in   1           request a dump; sampled only in IDLE
//  abort        in   1           cancel a dump in progress; no done pulse
//  readRegister out  5           index driven to register file read port
//  readData     in   DATA_WIDTH  combinational read data for readRegister
//  dumpValid    out  1           dumpIndex/dumpData hold a captured word
//  dumpReady    in   1           downstream accepts the word when dumpValid && dumpReady
//  dumpIndex    out  5           index of the presented word
//  dumpData     out  DATA_WIDTH  presented word
//  busy         out  1           high in READ, HOLD and DONE
//  done         out  1           one-cycle pulse after the LAST_REG word is accepted
//  checksum     out  DATA_WIDTH  XOR of all accepted words (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; readRegister, dumpIndex, dumpData, checksum = 0; dumpValid, busy, done = 0.
//  FSM states: IDLE, READ, HOLD, DONE.
//  IDLE:
//   - start=1 -> READ; index <= FIRST_REG; checksum <= 0.
//  READ (1 cycle):
//   - readRegister = index.
//   - At the edge: dumpData <= readData, dumpIndex <= index, dumpValid <= 1 -> HOLD.
//   - The captured value is the pre-edge value. A write to the same register on that edge is not visible.
//  HOLD:
//   - dumpValid=1. dumpData/dumpIndex are stable until the handshake completes.
//   - Handshake completes at the edge where dumpReady=1: dumpValid <= 0; checksum folds in dumpData.
//   - Then, if index==LAST_REG -> DONE; else index <= index+1 -> READ.
//  DONE (1 cycle):
//   - done=1, then -> IDLE. dumpData, dumpIndex and checksum retain their values until the next start.
//  Throughput: 2 cycles per word minimum (READ + HOLD with dumpReady=1).
//   - First dumpValid appears 2 cycles after start is sampled.
//   - done is high 1 cycle after the LAST_REG handshake.
//  readRegister holds the last driven index outside READ. Read-port contents outside READ are don't-care.
//  start while busy is ignored; no queuing.
//  abort=1 in any non-IDLE state -> IDLE next edge; dumpValid <= 0; done stays 0.
//   - abort has priority over the handshake in the same cycle.
//   - checksum is left as is.
//  reset has priority over abort, start and the handshake, in every state.
//  Index arithmetic is 5-bit; it never wraps, because termination is on index==LAST_REG.
//  FIRST_REG==LAST_REG: exactly one word, then done.
// CONFIGURATION
//  REG_DUMP_CHECKSUM_EN defined:
//   - checksum = running XOR of every accepted dumpData since the last start.
//   - It is final when done=1.
//  REG_DUMP_CHECKSUM_EN undefined:
//   - No accumulator is built; checksum is tied to 0.
//   - All other behaviour is identical.
// TESTING
//  T1 Full dump: regs r[i]=i*0x11111111, dumpReady=1; start pulse.
//   -> 32 words, index 0..31, data matching.
//   -> done exactly 65 cycles after start is sampled (64 + 1).
//   -> with macro, checksum = XOR of all r[i].
//  T2 Backpressure: dumpReady=0 for 5 cycles on word 3.
//   -> dumpValid stays 1; dumpIndex=3 and dumpData stable throughout; word 4 follows only after acceptance.
//  T3 Abort: abort at the HOLD of word 10.
//   -> next cycle: IDLE, busy=0, dumpValid=0, no done.
//   -> a new start restarts at FIRST_REG.
//  T4 Start while busy: pulse start during word 5.
//   -> ignored; the dump completes once with 32 words.
//  T5 Reset mid-dump, and write collision.
//   -> reset during word 20: all outputs 0 next cycle.
//   -> register file write of 0xDEADBEEF to r7 on the READ edge of word 7: dumpData shows the old value.
//  T6 FIRST_REG=LAST_REG=9, r9=0xCAFEF00D.
//   -> a single beat, dumpIndex=9; done follows.
//   -> checksum = 0xCAFEF00D with macro, 0 without.

Source files
------------

// File: rtl/reg_dump_reader.sv
// ============================================================================
//  Module      : reg_dump_reader
//  Description : Debug reader for the CPU register file. On a start pulse it
//                walks register indices FIRST_REG..LAST_REG through the
//                register file's combinational second read port, captures
//                each word and presents it downstream on a valid/ready
//                handshake. Optional XOR checksum of accepted words is built
//                when the macro REG_DUMP_CHECKSUM_EN is defined; otherwise
//                the checksum output is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_dump_reader #(
    parameter int FIRST_REG  = 0,
    parameter int LAST_REG   = 31,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [4:0]            readRegister,
    input  logic [DATA_WIDTH-1:0] readData,
    output logic                  dumpValid,
    input  logic                  dumpReady,
    output logic [4:0]            dumpIndex,
    output logic [DATA_WIDTH-1:0] dumpData,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam logic [4:0] c_FIRST = FIRST_REG[4:0];
    localparam logic [4:0] c_LAST  = LAST_REG[4:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [4:0]            r_index;
    logic                  r_dump_valid;
    logic [4:0]            r_dump_index;
    logic [DATA_WIDTH-1:0] r_dump_data;

    logic w_start;
    logic w_abort;
    logic w_accept;
    logic w_last;

    // A dump only begins from IDLE; abort is meaningful only while busy and
    // overrides a handshake landing on the same edge.
    assign w_start  = (r_state == S_IDLE) && start;
    assign w_abort  = (r_state != S_IDLE) && abort;
    assign w_accept = (r_state == S_HOLD) && dumpReady && !abort;
    assign w_last   = (r_index == c_LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; abort forces IDLE from any active state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_READ;
            S_READ:  w_next = S_HOLD;
            S_HOLD:  if (dumpReady) w_next = w_last ? S_DONE : S_READ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    // Index walk and capture of the read-port word into the output holding
    // registers. The index register also drives the read port, so the port
    // keeps showing the last index once the walk leaves READ.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_index      <= 5'd0;
            r_dump_valid <= 1'b0;
            r_dump_index <= 5'd0;
            r_dump_data  <= '0;
        end else begin
            if (w_start) begin
                r_index <= c_FIRST;
            end
            if ((r_state == S_READ) && !abort) begin
                r_dump_data  <= readData;
                r_dump_index <= r_index;
                r_dump_valid <= 1'b1;
            end
            if (w_accept) begin
                r_dump_valid <= 1'b0;
                if (!w_last) begin
                    r_index <= r_index + 5'd1;
                end
            end
            if (w_abort) begin
                r_dump_valid <= 1'b0;
            end
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    // Running XOR of accepted words, cleared when a new dump starts.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum ^ r_dump_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign readRegister = r_index;
    assign dumpValid    = r_dump_valid;
    assign dumpIndex    = r_dump_index;
    assign dumpData     = r_dump_data;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
// ============================================================================
//  Module      : tb_reg_dump_reader
//  Description : Directed self-checking bench for reg_dump_reader: full dump,
//                backpressure, abort, start while busy, reset mid-dump, read/
//                write collision and a single-register configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_dump_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        dumpReady;
    logic [4:0]  readRegister;
    logic [31:0] readData;
    logic        dumpValid;
    logic [4:0]  dumpIndex;
    logic [31:0] dumpData;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    logic        start2;
    logic        dumpReady2;
    logic [4:0]  readRegister2;
    logic [31:0] readData2;
    logic        dumpValid2;
    logic [4:0]  dumpIndex2;
    logic [31:0] dumpData2;
    logic        busy2;
    logic        done2;
    logic [31:0] checksum2;

    logic [31:0] regs [32];

    int n_cmp = 0;
    int n_err = 0;
    int first_v;

    assign readData  = regs[readRegister];
    assign readData2 = regs[readRegister2];

    always #5 clock = ~clock;

    reg_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .DATA_WIDTH(32)) u_dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .readRegister(readRegister), .readData(readData),
        .dumpValid(dumpValid), .dumpReady(dumpReady),
        .dumpIndex(dumpIndex), .dumpData(dumpData),
        .busy(busy), .done(done), .checksum(checksum)
    );

    reg_dump_reader #(.FIRST_REG(9), .LAST_REG(9), .DATA_WIDTH(32)) u_dut9 (
        .clock(clock), .reset(reset), .start(start2), .abort(abort),
        .readRegister(readRegister2), .readData(readData2),
        .dumpValid(dumpValid2), .dumpReady(dumpReady2),
        .dumpIndex(dumpIndex2), .dumpData(dumpData2),
        .busy(busy2), .done(done2), .checksum(checksum2)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'(i) * 32'h1111_1111;
    endfunction

    function automatic logic [31:0] cks(input logic [31:0] x);
`ifdef REG_DUMP_CHECKSUM_EN
        return x;
`else
        return (x & 32'h0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one dump on the main instance. Word-number arguments of -1
    // disable the corresponding disturbance.
    task automatic run_dump(input int stall_w, input int start_w, input int abort_w,
                            input int reset_w, input int coll_w,
                            output int words, output int done_cyc);
        int          cyc;
        int          exp_idx;
        logic [31:0] xs;
        logic        do_wr;
        logic        stop;
        words    = 0;
        done_cyc = 0;
        exp_idx  = 0;
        xs       = 32'h0;
        do_wr    = 1'b0;
        stop     = 1'b0;
        first_v  = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!stop && cyc < 400) begin
            if (done) begin
                done_cyc = cyc;
                chk("checksum_at_done", checksum, cks(xs));
                stop = 1'b1;
            end else if (dumpValid) begin
                if (first_v < 0) first_v = cyc;
                chk("word_index", dumpIndex, exp_idx);
                chk("word_data", dumpData, pat(exp_idx));
                if (exp_idx == abort_w) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    chk("abort_busy", busy, 0);
                    chk("abort_valid", dumpValid, 0);
                    chk("abort_done", done, 0);
                    tick();
                    chk("abort_done_later", done, 0);
                    chk("abort_checksum_kept", checksum, cks(xs));
                    stop = 1'b1;
                end else if (exp_idx == reset_w) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    chk("rst_busy", busy, 0);
                    chk("rst_valid", dumpValid, 0);
                    chk("rst_done", done, 0);
                    chk("rst_readreg", readRegister, 0);
                    chk("rst_index", dumpIndex, 0);
                    chk("rst_data", dumpData, 0);
                    chk("rst_checksum", checksum, 0);
                    stop = 1'b1;
                end else begin
                    if (exp_idx == stall_w) begin
                        dumpReady = 1'b0;
                        repeat (5) begin
                            tick();
                            cyc++;
                            chk("stall_valid", dumpValid, 1);
                            chk("stall_index", dumpIndex, exp_idx);
                            chk("stall_data", dumpData, pat(exp_idx));
                        end
                        dumpReady = 1'b1;
                    end
                    if (exp_idx == start_w) start = 1'b1;
                    xs = xs ^ pat(exp_idx);
                    exp_idx++;
                    words++;
                end
            end else if (coll_w >= 0 && busy && readRegister == 5'(coll_w)) begin
                do_wr = 1'b1;
            end
            if (!stop) begin
                @(posedge clock);
                if (do_wr) begin
                    regs[coll_w] <= 32'hDEAD_BEEF;
                    do_wr = 1'b0;
                end
                #1;
                cyc++;
                start = 1'b0;
            end
        end
        if (!stop) begin
            n_cmp++;
            n_err++;
            $error("FAIL dump_timeout: observed no done after %0d cycles, expected done", cyc);
        end
    endtask

    initial begin
        int words;
        int dcyc;
        logic [31:0] x9;

        for (int i = 0; i < 32; i++) regs[i] <= pat(i);
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        dumpReady  = 1'b1;
        start2     = 1'b0;
        dumpReady2 = 1'b1;
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_valid", dumpValid, 0);
        chk("reset_done", done, 0);
        chk("reset_readreg", readRegister, 0);
        chk("reset_index", dumpIndex, 0);
        chk("reset_data", dumpData, 0);
        chk("reset_checksum", checksum, 0);
        chk("reset_busy9", busy2, 0);
        reset = 1'b0;
        tick();

        // T1: full dump, no backpressure
        run_dump(-1, -1, -1, -1, -1, words, dcyc);
        chk("t1_words", words, 32);
        chk("t1_done_cycle", dcyc, 65);
        chk("t1_first_valid", first_v, 2);
        chk("t1_busy_at_done", busy, 1);
        chk("t1_last_index", dumpIndex, 31);
        tick();
        chk("t1_done_pulse_end", done, 0);
        chk("t1_idle", busy, 0);
        chk("t1_index_retained", dumpIndex, 31);
        chk("t1_data_retained", dumpData, pat(31));
        tick();

        // T3: abort on word 10 (with dumpReady high)
        run_dump(-1, -1, 10, -1, -1, words, dcyc);
        chk("t3_words_before_abort", words, 10);

        // T2 + T4: restart from FIRST_REG, stall word 3, start pulse on word 5
        run_dump(3, 5, -1, -1, -1, words, dcyc);
        chk("t24_words", words, 32);
        chk("t24_done_cycle", dcyc, 70);
        tick();
        chk("t24_single_done", done, 0);
        chk("t24_no_requeue", busy, 0);
        tick();
        chk("t24_still_idle", busy, 0);

        // T5: write collision on word 7, reset during word 20
        run_dump(-1, -1, -1, 20, 7, words, dcyc);
        chk("t5_words_before_reset", words, 20);
        chk("t5_regfile_written", regs[7], 32'hDEAD_BEEF);
        regs[7] <= pat(7);
        tick();

        // T6: single-register configuration
        regs[9] <= 32'hCAFE_F00D;
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("t6_busy", busy2, 1);
        chk("t6_valid_early", dumpValid2, 0);
        chk("t6_readreg", readRegister2, 9);
        tick();
        chk("t6_valid", dumpValid2, 1);
        chk("t6_index", dumpIndex2, 9);
        chk("t6_data", dumpData2, 32'hCAFE_F00D);
        tick();
        x9 = 32'hCAFE_F00D;
        chk("t6_done", done2, 1);
        chk("t6_valid_cleared", dumpValid2, 0);
        chk("t6_checksum", checksum2, cks(x9));
        tick();
        chk("t6_done_end", done2, 0);
        chk("t6_idle", busy2, 0);
        chk("t6_index_kept", dumpIndex2, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
